// File: rtl/fixu_mc.sv
// fixu_mc: multi-cycle signed Q(WID-FRAC).FRAC arithmetic unit behind a two-phase req/ack handshake.
// Define FIXU_MC_SAT_EN to saturate out-of-range results; the default build wraps them.
module fixu_mc #(
  parameter int WID  = 16,
  parameter int FRAC = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           enable,
  input  logic           req,
  input  logic [2:0]     fn,
  input  logic [WID-1:0] a,
  input  logic [WID-1:0] b,
  input  logic [WID-1:0] c,
  output logic           ack,
  output logic [WID-1:0] z,
  output logic           overflow,
  output logic           busy
);

  localparam int N  = WID + FRAC;     // quotient bits, one per divide cycle
  localparam int EW = 2 * WID + 2;    // wide enough for any exact result
  localparam int CW = $clog2(N + 1);

  localparam logic signed [EW-1:0] MAXV = {{(EW-WID+1){1'b0}}, {(WID-1){1'b1}}};
  localparam logic signed [EW-1:0] MINV = {{(EW-WID+1){1'b1}}, {(WID-1){1'b0}}};

  typedef enum logic [2:0] {
    F_ADD = 3'd0, F_SUB = 3'd1, F_MUL = 3'd2,
    F_MAC = 3'd3, F_MSU = 3'd4, F_DIV = 3'd5
  } fn_e;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DIV, S_FIN} state_e;

  state_e           state;
  fn_e              fn_q;
  logic             req_d;
  logic [WID-1:0]   a_q, b_q, c_q;
  logic             neg_q;
  logic [CW-1:0]    cnt;
  logic [N-1:0]     dvd;              // dividend shifts out, quotient shifts in
  logic [WID:0]     dvs, rem, a_mag, b_mag;

  logic signed [EW-1:0] a_x, b_x, c_x, prod, prod_sh, exec_res, div_res, res;
  logic [WID+1:0]   rem_sh;
  logic             sub_ok, force_ov, out_of_range, ov_nx;
  logic [WID:0]     rem_nx;
  logic [WID-1:0]   z_nx;

  assign busy  = (state != S_IDLE);
  assign a_mag = a[WID-1] ? -{1'b1, a} : {1'b0, a};
  assign b_mag = b[WID-1] ? -{1'b1, b} : {1'b0, b};

  assign a_x     = {{(EW-WID){a_q[WID-1]}}, a_q};
  assign b_x     = {{(EW-WID){b_q[WID-1]}}, b_q};
  assign c_x     = {{(EW-WID){c_q[WID-1]}}, c_q};
  assign prod    = a_x * b_x;
  assign prod_sh = prod >>> FRAC;
  assign div_res = neg_q ? -{{(EW-N){1'b0}}, dvd} : {{(EW-N){1'b0}}, dvd};

  // One restoring step: bring down the next dividend bit, subtract if it fits.
  assign rem_sh = {rem, dvd[N-1]};
  assign sub_ok = (rem_sh >= {1'b0, dvs});
  assign rem_nx = sub_ok ? (WID+1)'(rem_sh - {1'b0, dvs}) : (WID+1)'(rem_sh);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no latch is inferred.
    exec_res = a_x + b_x;
    force_ov = 1'b0;
    case (fn_q)
      F_ADD, F_DIV: exec_res = a_x + b_x;
      F_SUB:        exec_res = a_x - b_x;
      F_MUL:        exec_res = prod_sh;
      F_MAC:        exec_res = prod_sh + c_x;
      F_MSU:        exec_res = c_x - prod_sh;
      default:      force_ov = 1'b1;
    endcase
    res          = (state == S_FIN) ? div_res : exec_res;
    out_of_range = (res > MAXV) || (res < MINV);
    z_nx         = res[WID-1:0];
`ifdef FIXU_MC_SAT_EN
    if (out_of_range) z_nx = res[EW-1] ? MINV[WID-1:0] : MAXV[WID-1:0];
`endif
    ov_nx = out_of_range || force_ov;
    // A divide reaching EXEC can only be a divide by zero.
    if (state == S_EXEC && fn_q == F_DIV) begin
      z_nx  = a_q[WID-1] ? MINV[WID-1:0] : MAXV[WID-1:0];
      ov_nx = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      req_d    <= req;
      ack      <= 1'b0;
      z        <= '0;
      overflow <= 1'b0;
      cnt      <= '0;
    end else if (enable) begin
      // NOTE: operand and divider registers are left out of reset; they are always loaded before use.
      case (state)
        S_IDLE: if (req != req_d) begin
          req_d <= req;
          fn_q  <= fn_e'(fn);
          a_q   <= a;
          b_q   <= b;
          c_q   <= c;
          neg_q <= a[WID-1] ^ b[WID-1];
          dvd   <= N'(a_mag) << FRAC;
          dvs   <= b_mag;
          rem   <= '0;
          cnt   <= '0;
          state <= (fn == 3'd5 && b != '0) ? S_DIV : S_EXEC;
        end
        S_DIV: begin
          dvd <= {dvd[N-2:0], sub_ok};
          rem <= rem_nx;
          if (cnt == CW'(N - 1)) begin
            cnt   <= '0;
            state <= S_FIN;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_EXEC, S_FIN: begin
          z        <= z_nx;
          overflow <= ov_nx;
          ack      <= ~ack;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
